// File: rtl/approx_mul_pipe.sv
`default_nettype none
// ============================================================================
// Module   : approx_mul_pipe
// Purpose  : 3-stage valid/ready approximate multiplier with per-quadrant
//            truncation modes. Optional error statistics: APPROX_ERR_STAT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module approx_mul_pipe #(
  parameter int W     = 4,
  parameter int TRUNC = 2
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [2*W-1:0] a,
  input  logic [2*W-1:0] b,
  input  logic [7:0]     mode,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [4*W-1:0] prod
`ifdef APPROX_ERR_STAT_EN
  ,
  output logic [15:0]    err_cnt,
  output logic [4*W-1:0] err_max
`endif
);

  localparam int c_pw = 2 * W;
  localparam int c_rw = 4 * W;
  // TRUNC=0 yields an all-zero mask, so modes 1 and 2 collapse to exact.
  localparam logic [c_pw-1:0] c_trunc_mask = {c_pw{1'b1}} >> (c_pw - TRUNC);

  localparam logic [1:0] c_mode_zero = 2'd1;
  localparam logic [1:0] c_mode_one  = 2'd2;

  logic w_en;

  logic            r_v1;
  logic [c_pw-1:0] r_a;
  logic [c_pw-1:0] r_b;
  logic [7:0]      r_mode;

  logic            r_v2;
  logic [c_pw-1:0] r_pp [4];

  logic            r_v3;
  logic [c_rw-1:0] r_prod;

  logic [c_pw-1:0] w_pp  [4];
  logic [c_rw-1:0] w_ext [4];
  logic [c_rw-1:0] w_sum;

  // One shared enable: the whole pipe moves unless the output is blocked.
  assign w_en      = ~r_v3 | out_ready;
  assign in_ready  = w_en;
  assign out_valid = r_v3;
  assign prod      = r_prod;

  // Stage 1: capture operands and mode at accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_v1   <= 1'b0;
      r_a    <= '0;
      r_b    <= '0;
      r_mode <= '0;
    end else if (w_en) begin
      r_v1 <= in_valid;
      if (in_valid) begin
        r_a    <= a;
        r_b    <= b;
        r_mode <= mode;
      end
    end
  end

  // Quadrant q: bit1 selects the high half of a, bit0 the high half of b.
  // Order 0..3 = ll, lh, hl, hh, matching the mode field layout.
  for (genvar q = 0; q < 4; q++) begin : g_quad
    logic [W-1:0]    w_x;
    logic [W-1:0]    w_y;
    logic [c_pw-1:0] w_raw;
    logic [1:0]      w_m;

    assign w_x   = ((q & 2) != 0) ? r_a[c_pw-1:W] : r_a[W-1:0];
    assign w_y   = ((q & 1) != 0) ? r_b[c_pw-1:W] : r_b[W-1:0];
    assign w_raw = {{W{1'b0}}, w_x} * {{W{1'b0}}, w_y};
    assign w_m   = r_mode[2*q+1 -: 2];

    assign w_pp[q] = (w_m == c_mode_zero) ? (w_raw & ~c_trunc_mask) :
                     (w_m == c_mode_one)  ? (w_raw |  c_trunc_mask) :
                                            w_raw;
    assign w_ext[q] = {{c_pw{1'b0}}, r_pp[q]};
  end

  // Stage 2: moded partial products.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_v2 <= 1'b0;
      for (int q = 0; q < 4; q++) begin
        r_pp[q] <= '0;
      end
    end else if (w_en) begin
      r_v2 <= r_v1;
      if (r_v1) begin
        for (int q = 0; q < 4; q++) begin
          r_pp[q] <= w_pp[q];
        end
      end
    end
  end

  assign w_sum = (w_ext[3] << c_pw) + ((w_ext[2] + w_ext[1]) << W) + w_ext[0];

  // Stage 3: accumulated product.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_v3   <= 1'b0;
      r_prod <= '0;
    end else if (w_en) begin
      r_v3 <= r_v2;
      if (r_v2) begin
        r_prod <= w_sum;
      end
    end
  end

`ifdef APPROX_ERR_STAT_EN
  logic [c_rw-1:0] r_exact2;
  logic [c_rw-1:0] r_exact3;
  logic [15:0]     r_err_cnt;
  logic [c_rw-1:0] r_err_max;
  logic [c_rw-1:0] w_diff;
  logic            w_consume;

  // Exact reference rides alongside the approximate path.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_exact2 <= '0;
      r_exact3 <= '0;
    end else if (w_en) begin
      if (r_v1) begin
        r_exact2 <= {{c_pw{1'b0}}, r_a} * {{c_pw{1'b0}}, r_b};
      end
      if (r_v2) begin
        r_exact3 <= r_exact2;
      end
    end
  end

  assign w_consume = r_v3 & out_ready;
  assign w_diff    = (r_prod >= r_exact3) ? (r_prod - r_exact3) : (r_exact3 - r_prod);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err_cnt <= '0;
      r_err_max <= '0;
    end else if (w_consume) begin
      if ((w_diff != '0) && (r_err_cnt != 16'hFFFF)) begin
        r_err_cnt <= r_err_cnt + 16'd1;
      end
      if (w_diff > r_err_max) begin
        r_err_max <= w_diff;
      end
    end
  end

  assign err_cnt = r_err_cnt;
  assign err_max = r_err_max;
`endif

endmodule
`default_nettype wire

// File: tb/tb_approx_mul_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_approx_mul_pipe
// Purpose  : Directed self-checking bench for approx_mul_pipe (W=4, TRUNC=2).
// Revision : 1.0 - initial release
// ============================================================================
module tb_approx_mul_pipe;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  a;
  logic [7:0]  b;
  logic [7:0]  mode;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] prod;
`ifdef APPROX_ERR_STAT_EN
  logic [15:0] err_cnt;
  logic [15:0] err_max;
`endif

  int checks;
  int errors;

  approx_mul_pipe #(.W(4), .TRUNC(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .mode      (mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .prod      (prod)
`ifdef APPROX_ERR_STAT_EN
    ,
    .err_cnt   (err_cnt),
    .err_max   (err_max)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Issue one beat, scramble inputs after accept, then measure latency and
  // check the delivered product; the final negedge lets the consume happen.
  task automatic single(input string tag, input logic [7:0] ta, input logic [7:0] tb_,
                        input logic [7:0] tm, input logic [15:0] exp);
    int lat;
    @(negedge clk);
    a = ta; b = tb_; mode = tm; in_valid = 1'b1;
    #1;
    chk({tag, "_in_ready"}, {31'd0, in_ready}, 32'd1);
    @(negedge clk);
    in_valid = 1'b0; a = ~ta; b = ~tb_; mode = 8'hAA;
    lat = 1;
    while (!out_valid && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    chk({tag, "_latency"}, lat, 32'd3);
    chk({tag, "_prod"}, {16'd0, prod}, {16'd0, exp});
    @(negedge clk);
  endtask

  initial begin
    logic [15:0] held;
    logic        stalled;
    int          sent;
    int          recv;
    int          cyc;
    int          stale;
    logic [15:0] exp;

    checks = 0; errors = 0;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    a = '0; b = '0; mode = '0;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_prod", {16'd0, prod}, 32'd0);
`ifdef APPROX_ERR_STAT_EN
    chk("rst_err_cnt", {16'd0, err_cnt}, 32'd0);
    chk("rst_err_max", {16'd0, err_max}, 32'd0);
`endif
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_in_ready", {31'd0, in_ready}, 32'd1);

    // Full-scale exact and per-mode ll variants (0x37*0x5B = 0x138D)
    single("ff_x_ff", 8'hFF, 8'hFF, 8'h00, 16'hFE01);
    single("ll_zero", 8'h37, 8'h5B, 8'h01, 16'h138C);
    single("ll_one",  8'h37, 8'h5B, 8'h02, 16'h138F);
    single("ll_rsvd", 8'h37, 8'h5B, 8'h03, 16'h138D);
    // hh mode 1: 15 -> 12, product drops by 3<<8
    single("hh_zero", 8'h37, 8'h5B, 8'h40, 16'h108D);
    // The task changes mode right after accept; result must be unaffected
    single("mode_late", 8'h37, 8'h5B, 8'h01, 16'h138C);

    // Streaming with out_ready pattern 1,0,0,1
    sent = 0; recv = 0; cyc = 0; stalled = 1'b0; held = '0;
    while (recv < 8 && cyc < 200) begin
      @(negedge clk);
      if (stalled) begin
        chk("stall_hold_valid", {31'd0, out_valid}, 32'd1);
        chk("stall_hold_prod", {16'd0, prod}, {16'd0, held});
      end
      out_ready = ((cyc % 4) == 0) || ((cyc % 4) == 3);
      in_valid  = (sent < 8);
      a = 8'(sent); b = 8'(sent + 1); mode = 8'h00;
      #1;
      if (out_valid && !out_ready) begin
        chk("stall_in_ready", {31'd0, in_ready}, 32'd0);
      end
      if (out_valid && out_ready) begin
        exp = 16'(recv * (recv + 1));
        chk("stream_prod", {16'd0, prod}, {16'd0, exp});
        recv++;
      end
      stalled = out_valid && !out_ready;
      held    = prod;
      if (in_valid && in_ready) sent++;
      cyc++;
    end
    chk("stream_count", recv, 32'd8);
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (4) @(negedge clk);

    // Reset with three beats in flight
    for (int i = 0; i < 3; i++) begin
      a = 8'h11 + 8'(i); b = 8'h22; mode = 8'h00; in_valid = 1'b1;
      @(negedge clk);
    end
    in_valid = 1'b0;
    chk("inflight_valid", {31'd0, out_valid}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("midrst_prod", {16'd0, prod}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    stale = 0;
    repeat (8) begin
      @(negedge clk);
      if (out_valid) stale++;
    end
    chk("no_stale_beat", stale, 32'd0);

`ifdef APPROX_ERR_STAT_EN
    single("stat_one", 8'h37, 8'h5B, 8'h02, 16'h138F);
    chk("stat_cnt", {16'd0, err_cnt}, 32'd1);
    chk("stat_max", {16'd0, err_max}, 32'd2);
    single("stat_exact", 8'hFF, 8'hFF, 8'h00, 16'hFE01);
    chk("stat_cnt_hold", {16'd0, err_cnt}, 32'd1);
    chk("stat_max_hold", {16'd0, err_max}, 32'd2);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
